// File: rtl/cci_mpf_prim_arb_pkg.sv
`default_nettype none
// ============================================================================
// cci_mpf_prim_arb_pkg : shared types and round-robin helper for MPF arbiters
// Revision: 1.0
// ============================================================================

package cci_mpf_prim_arb_pkg;

  localparam int ARB_WEIGHT_BITS = 4;
  localparam int ARB_MAX_CLIENTS = 32;

  typedef logic [ARB_WEIGHT_BITS-1:0] t_arb_weight;
  typedef logic [ARB_MAX_CLIENTS-1:0] t_arb_vec;

  // Generic-width round-robin pick; request bits at or above n must be zero
  // and base must be one-hot within the low n bits.
  function automatic t_arb_vec arb_rr_pick(input t_arb_vec request,
                                           input t_arb_vec base,
                                           input int unsigned n);
    logic [2*ARB_MAX_CLIENTS-1:0] dbl;
    logic [2*ARB_MAX_CLIENTS-1:0] win;
    t_arb_vec                     mask;
    dbl  = {{ARB_MAX_CLIENTS{1'b0}}, request} |
           ({{ARB_MAX_CLIENTS{1'b0}}, request} << n);
    win  = dbl & ~(dbl - {{ARB_MAX_CLIENTS{1'b0}}, base});
    mask = (t_arb_vec'(1) << n) - t_arb_vec'(1);
    return (win[ARB_MAX_CLIENTS-1:0] | t_arb_vec'(win >> n)) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cci_mpf_prim_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// cci_mpf_prim_arb_rr_pick : combinational round-robin pick (one-hot + index)
// Revision: 1.0
// ============================================================================

module cci_mpf_prim_arb_rr_pick
  import cci_mpf_prim_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int IDX_BITS    = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] request,
  input  logic [NUM_CLIENTS-1:0] base,
  output logic [NUM_CLIENTS-1:0] pick_oh,
  output logic [IDX_BITS-1:0]    pick_idx
);

  logic [2*NUM_CLIENTS-1:0] w_dbl;
  logic [2*NUM_CLIENTS-1:0] w_win;

  // Subtracting base clears everything below the first requester at/after it.
  assign w_dbl   = {request, request};
  assign w_win   = w_dbl & ~(w_dbl - {{NUM_CLIENTS{1'b0}}, base});
  assign pick_oh = w_win[NUM_CLIENTS-1:0] | w_win[2*NUM_CLIENTS-1:NUM_CLIENTS];

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_oh[i]) pick_idx = IDX_BITS'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/cci_mpf_prim_arb_wrr.sv
`default_nettype none
// ============================================================================
// cci_mpf_prim_arb_wrr : weighted round-robin arbiter with per-client lock
// Revision: 1.0
// ============================================================================

module cci_mpf_prim_arb_wrr
  import cci_mpf_prim_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int WEIGHT_BITS = ARB_WEIGHT_BITS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ena,
  input  logic [NUM_CLIENTS-1:0]             request,
  input  logic [NUM_CLIENTS-1:0]             lock,
  input  logic [NUM_CLIENTS*WEIGHT_BITS-1:0] weight,
  output logic [NUM_CLIENTS-1:0]             grant,
  output logic [$clog2(NUM_CLIENTS)-1:0]     grantIdx,
  output logic                               grantOwned
);

  localparam int IDX_BITS = $clog2(NUM_CLIENTS);

  logic [NUM_CLIENTS-1:0] base_q, base_d;
  logic [IDX_BITS-1:0]    owner_q, owner_d;
  logic                   owner_valid_q, owner_valid_d;
  logic [WEIGHT_BITS-1:0] credit_q, credit_d;

  logic [WEIGHT_BITS-1:0] w_weight [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] w_pick_oh;
  logic [IDX_BITS-1:0]    w_pick_idx;
  logic                   w_hold;
  logic                   w_grant_cycle;
  logic [IDX_BITS-1:0]    w_cand_idx;
  logic [NUM_CLIENTS-1:0] w_cand_oh;
  logic [WEIGHT_BITS-1:0] w_credit_next;

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_weight
    assign w_weight[i] = weight[i*WEIGHT_BITS +: WEIGHT_BITS];
  end

  cci_mpf_prim_arb_rr_pick #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_BITS    (IDX_BITS)
  ) u_pick (
    .request  (request),
    .base     (base_q),
    .pick_oh  (w_pick_oh),
    .pick_idx (w_pick_idx)
  );

  assign w_hold        = owner_valid_q && request[owner_q];
  assign w_grant_cycle = ena && (|request);
  assign w_cand_idx    = w_hold ? owner_q : w_pick_idx;
  assign w_cand_oh     = w_hold ? ({{(NUM_CLIENTS-1){1'b0}}, 1'b1} << owner_q) : w_pick_oh;

  assign grant      = w_cand_oh & {NUM_CLIENTS{w_grant_cycle}};
  assign grantIdx   = w_cand_idx;
  assign grantOwned = w_hold;

  always_comb begin
    w_credit_next = '0;
    if (w_hold) begin
      w_credit_next = (credit_q == '0) ? '0 : credit_q - WEIGHT_BITS'(1);
    end else if (w_weight[w_pick_idx] != '0) begin
      w_credit_next = w_weight[w_pick_idx] - WEIGHT_BITS'(1);
    end
  end

  always_comb begin
    base_d        = base_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    credit_d      = credit_q;
    if (w_grant_cycle) begin
      owner_d       = w_cand_idx;
      credit_d      = w_credit_next;
      owner_valid_d = (w_credit_next != '0) || lock[w_cand_idx];
      if (!w_hold) base_d = {w_pick_oh[NUM_CLIENTS-2:0], w_pick_oh[NUM_CLIENTS-1]};
    end else if (owner_valid_q && !request[owner_q]) begin
      // An owner that lets go of its request forfeits remaining credit.
      owner_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q        <= {{(NUM_CLIENTS-1){1'b0}}, 1'b1};
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      credit_q      <= '0;
    end else begin
      base_q        <= base_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      credit_q      <= credit_d;
    end
  end

endmodule

`default_nettype wire
